seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//   Parametrised multi-cycle ALU; successor to the fixed 4-bit combinational ALU.
//   - Operand width is a parameter.
//   - Valid/ready handshakes on both the operand and result sides.
//   - MUL and DIV are iterative (one bit per cycle) to save area.
//   - Drives result flags; sits between the pin-level operand/opcode capture and the output mux.
// PARAMETERS
//   W    4   operand width in bits (>=2); result width is 2*W
// PORTS
//   clk        in   1    clock; all state updates on rising edge
//   rst_n      in   1    reset, asynchronous assert, active-low
//   in_valid   in   1    operand/opcode presented
//   in_ready   out  1    block can accept (high only in IDLE)
//   op         in   3    opcode, decoded below
//   a          in   W    operand A (unsigned)
//   b          in   W    operand B (unsigned)
//   out_valid  out  1    result held valid (DONE state)
//   out_ready  in   1    consumer takes result
//   result     out  2W   result, held stable while out_valid
//   flags      out  3    {err, carry, zero}, held with result
// BEHAVIOUR
//   Reset: state=IDLE, in_ready=1, out_valid=0, result=0, flags=0, iteration counter=0.
//   Opcodes (zero-extend unused result bits):
//     000 ADD  result[W:0]=a+b; carry=result[W]
//     001 SUB  result[W:0]=(a-b) mod 2^(W+1); carry=borrow (a<b)
//     010 MUL  result=a*b (full 2W)
//     011 DIV  result[W-1:0]=a/b, result[2W-1:W]=a%b
//     100 AND, 101 OR, 110 XOR  result[W-1:0]
//     111 CMP  result[0]=(a<b), result[1]=(a==b)
//   zero = (result==0) for every op; err=0 except DIV by zero.
//   FSM: IDLE -> (in_valid) capture a,b,op -> BUSY or DONE
//        BUSY -> after W iterations -> DONE
//        DONE -> (out_ready) -> IDLE
//   - Transfer on in_valid&in_ready; operands latched, input ports ignored afterwards.
//   - in_valid outside IDLE is ignored; no pipelining, one op in flight.
//   Latency from accept edge to out_valid: 1 cycle for single-cycle ops; W+1 for MUL/DIV.
//   MUL: shift-add, 1 multiplier bit per cycle, W-bit down-counter.
//   DIV: restoring, 1 quotient bit per cycle.
//   DIV with b=0: no iteration, DONE next cycle.
//     - quotient = all-ones, remainder = a, err=1.
//   DONE holds result/flags unchanged for any number of out_ready=0 cycles.
//   DONE & out_ready: IDLE next cycle; in_ready rises the cycle after the handshake.
//   rst_n low in any state (incl. mid-iteration) aborts the op and restores reset values at once.
// CONFIGURATION
//   SEQ_ALU_DIV_EN defined: divider built as above.
//   SEQ_ALU_DIV_EN undefined: no divider logic.
//     - op 011 goes to DONE in 1 cycle with result=0, err=1, zero=1, carry=0.
// TESTING (W=4)
//   ADD a=9,b=8 -> out_valid 1 cycle after accept; result=8'h11, flags=3'b010
//   SUB a=3,b=5 -> result=8'h1E, carry=1, zero=0
//   MUL a=15,b=15 -> out_valid exactly 5 cycles after accept; result=8'hE1
//   DIV a=13,b=4 -> result=8'h13, err=0; DIV a=7,b=0 -> result=8'h7F, err=1 (1-cycle latency)
//   Hold out_ready=0 3 cycles in DONE, toggle a/b/in_valid -> result stable, in_ready=0, no new accept
//   Assert rst_n=0 on 2nd MUL iteration -> out_valid=0, in_ready=1; next ADD 2+2 -> result=8'h04

Source files
------------

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// seq_alu : multi-cycle ALU with valid/ready handshakes, iterative MUL/DIV.
// Divider built only when SEQ_ALU_DIV_EN is defined.        Revision: 1.0
// ============================================================================
module seq_alu #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic [2:0]     flags
);

  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   opnd;      // multiplicand for MUL, divisor for DIV
  logic [W-1:0]   acc;       // product high half / partial remainder
  logic [W-1:0]   lo;        // multiplier bits / dividend-then-quotient bits
  logic [CW-1:0]  cnt;
  logic [W-1:0]   acc_nxt, lo_nxt;
  logic [2*W-1:0] quick_res;
  logic           quick_err, quick_carry;
  logic           is_multi;
  logic           iter_last;
  logic [W:0]     mul_sum;

`ifdef SEQ_ALU_DIV_EN
  logic           div_mode;
  logic [W:0]     div_shift, div_trial;
  assign is_multi = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
`else
  assign is_multi = (op == OP_MUL);
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign iter_last = (cnt == CW'(1));

  // Results for every op that completes on the accept edge.
  always_comb begin
    quick_res   = '0;
    quick_err   = 1'b0;
    quick_carry = 1'b0;
    case (op)
      OP_ADD: begin
        quick_res[W:0] = {1'b0, a} + {1'b0, b};
        quick_carry    = quick_res[W];
      end
      OP_SUB: begin
        quick_res[W:0] = {1'b0, a} - {1'b0, b};
        quick_carry    = (a < b);
      end
      OP_DIV: begin
`ifdef SEQ_ALU_DIV_EN
        quick_res = {a, {W{1'b1}}};
`endif
        quick_err = 1'b1;
      end
      OP_AND: quick_res[W-1:0] = a & b;
      OP_OR:  quick_res[W-1:0] = a | b;
      OP_XOR: quick_res[W-1:0] = a ^ b;
      OP_CMP: begin
        quick_res[0] = (a < b);
        quick_res[1] = (a == b);
      end
      default: ;
    endcase
  end

  // One shift-add or restoring-divide step per BUSY cycle.
  always_comb begin
    mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    acc_nxt = mul_sum[W:1];
    lo_nxt  = {mul_sum[0], lo[W-1:1]};
`ifdef SEQ_ALU_DIV_EN
    div_shift = {acc, lo[W-1]};
    div_trial = div_shift - {1'b0, opnd};
    if (div_mode) begin
      if (!div_trial[W]) begin
        acc_nxt = div_trial[W-1:0];
        lo_nxt  = {lo[W-2:0], 1'b1};
      end else begin
        acc_nxt = div_shift[W-1:0];
        lo_nxt  = {lo[W-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = is_multi ? BUSY : DONE;
      BUSY:    if (iter_last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd   <= '0;
      acc    <= '0;
      lo     <= '0;
      cnt    <= '0;
      result <= '0;
      flags  <= '0;
`ifdef SEQ_ALU_DIV_EN
      div_mode <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (is_multi) begin
            opnd <= (op == OP_MUL) ? a : b;
            lo   <= (op == OP_MUL) ? b : a;
            acc  <= '0;
            cnt  <= CW'(W);
`ifdef SEQ_ALU_DIV_EN
            div_mode <= (op == OP_DIV);
`endif
          end else begin
            result <= quick_res;
            flags  <= {quick_err, quick_carry, (quick_res == '0)};
          end
        end
        BUSY: begin
          acc <= acc_nxt;
          lo  <= lo_nxt;
          cnt <= cnt - CW'(1);
          if (iter_last) begin
            result <= {acc_nxt, lo_nxt};
            flags  <= {2'b00, ({acc_nxt, lo_nxt} == '0)};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// tb_seq_alu : directed self-checking bench for seq_alu at W=4.
// Revision: 1.0
// ============================================================================
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [3:0] a, b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [2:0] flags;

  int checks = 0;
  int errors = 0;
  int lat;

  seq_alu #(.W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
  endtask

  // Counts negedges after the accept edge until out_valid, bounded.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 20);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [3:0] x,
                     input logic [3:0] y, input int exp_lat, input logic [7:0] exp_res,
                     input logic [2:0] exp_flags);
    int n;
    start(o, x, y);
    wait_done(n);
    check({tag, ".latency"}, n, exp_lat);
    check({tag, ".result"}, result, exp_res);
    check({tag, ".flags"}, flags, exp_flags);
    drain();
    check({tag, ".in_ready_after"}, in_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; a = 4'd0; b = 4'd0;
    #12;
    check("reset.in_ready", in_ready, 1'b1);
    check("reset.out_valid", out_valid, 1'b0);
    check("reset.result", result, 8'h00);
    check("reset.flags", flags, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    run("add_9_8",   3'd0, 4'd9,  4'd8,  1, 8'h11, 3'b010);
    run("sub_3_5",   3'd1, 4'd3,  4'd5,  1, 8'h1E, 3'b010);
    run("mul_15_15", 3'd2, 4'd15, 4'd15, 5, 8'hE1, 3'b000);
`ifdef SEQ_ALU_DIV_EN
    run("div_13_4",  3'd3, 4'd13, 4'd4,  5, 8'h13, 3'b000);
    run("div_7_0",   3'd3, 4'd7,  4'd0,  1, 8'h7F, 3'b100);
`else
    run("div_13_4",  3'd3, 4'd13, 4'd4,  1, 8'h00, 3'b101);
    run("div_7_0",   3'd3, 4'd7,  4'd0,  1, 8'h00, 3'b101);
`endif
    run("and_12_10", 3'd4, 4'd12, 4'd10, 1, 8'h08, 3'b000);
    run("or_0_0",    3'd5, 4'd0,  4'd0,  1, 8'h00, 3'b001);
    run("xor_5_5",   3'd6, 4'd5,  4'd5,  1, 8'h00, 3'b001);
    run("xor_9_6",   3'd6, 4'd9,  4'd6,  1, 8'h0F, 3'b000);
    run("cmp_3_7",   3'd7, 4'd3,  4'd7,  1, 8'h01, 3'b000);
    run("cmp_7_7",   3'd7, 4'd7,  4'd7,  1, 8'h02, 3'b000);
    run("cmp_9_2",   3'd7, 4'd9,  4'd2,  1, 8'h00, 3'b001);
    run("add_15_15", 3'd0, 4'd15, 4'd15, 1, 8'h1E, 3'b010);
    run("sub_5_5",   3'd1, 4'd5,  4'd5,  1, 8'h00, 3'b001);
    run("mul_0_9",   3'd2, 4'd0,  4'd9,  5, 8'h00, 3'b001);
    run("mul_6_11",  3'd2, 4'd6,  4'd11, 5, 8'h42, 3'b000);

    // DONE holds while the consumer stalls and new requests are offered.
    start(3'd0, 4'd1, 4'd2);
    wait_done(lat);
    check("hold.latency", lat, 1);
    for (int i = 0; i < 3; i++) begin
      op = 3'd2; a = 4'(i + 7); b = 4'(12 - i); in_valid = ~in_valid;
      @(posedge clk);
      @(negedge clk);
      check("hold.result", result, 8'h03);
      check("hold.flags", flags, 3'b000);
      check("hold.in_ready", in_ready, 1'b0);
      check("hold.out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    drain();
    check("hold.released_in_ready", in_ready, 1'b1);
    check("hold.released_out_valid", out_valid, 1'b0);
    check("hold.released_result", result, 8'h03);
    @(negedge clk);
    check("hold.no_accept", in_ready, 1'b1);

    // Reset during the second MUL iteration aborts the operation.
    start(3'd2, 4'd15, 4'd15);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.out_valid", out_valid, 1'b0);
    check("abort.in_ready", in_ready, 1'b1);
    check("abort.result", result, 8'h00);
    check("abort.flags", flags, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    run("add_2_2", 3'd0, 4'd2, 4'd2, 1, 8'h04, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
